// File: rtl/inst_fetch_queue_if.sv
// Fetch-side signal bundle: control inputs, imem request/response, decoder handoff.
// master = fetch queue, slave = surrounding environment (core control, imem, decoder).
interface inst_fetch_queue_if #(
    parameter int unsigned ADDR_W = 32
);
    logic              halt;
    logic              redirect_valid;
    logic [ADDR_W-1:0] redirect_pc;
    logic              imem_req_valid;
    logic              imem_req_ready;
    logic [ADDR_W-1:0] imem_req_addr;
    logic              imem_rsp_valid;
    logic [31:0]       imem_rsp_data;
    logic [31:0]       inst;
    logic [ADDR_W-1:0] inst_pc;
    logic              inst_valid;
    logic              inst_ready;

    modport master (
        input  halt, redirect_valid, redirect_pc,
        input  imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        output imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid
    );

    modport slave (
        output halt, redirect_valid, redirect_pc,
        output imem_req_ready, imem_rsp_valid, imem_rsp_data, inst_ready,
        input  imem_req_valid, imem_req_addr, inst, inst_pc, inst_valid
    );
endinterface

// File: rtl/inst_fetch_queue.sv
// In-order instruction fetch with credit-limited prefetch queue and redirect/flush.
// Optional FETCH_PERF_CNT_EN adds a saturating fetch-starvation counter output.
module inst_fetch_queue #(
    parameter int unsigned      ADDR_W   = 32,
    parameter int unsigned      DEPTH    = 4,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic clk,
    input  logic rst,
    inst_fetch_queue_if.master bus
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_stall_cnt
`endif
);
    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned SUM_W = CNT_W + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_next;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_rsp_pc;
    logic [CNT_W-1:0]  r_out;
    logic [CNT_W-1:0]  r_drop;
    logic [CNT_W-1:0]  r_count;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [31:0]       r_inst_mem [DEPTH];
    logic [ADDR_W-1:0] r_pc_mem   [DEPTH];

    logic              w_credit_ok;
    logic              w_req_valid;
    logic              w_req_fire;
    logic              w_rsp;
    logic              w_rsp_drop;
    logic              w_push;
    logic              w_pop;
    logic              w_head_valid;
    logic [CNT_W-1:0]  w_out_next;
    logic [CNT_W-1:0]  w_drop_next;
    logic [ADDR_W-1:0] w_redir_pc;

    assign w_redir_pc = bus.redirect_pc & ~ADDR_W'(3);

    // Handshake decode and next-state; a response with nothing outstanding is ignored
    always_comb begin
        w_state_next = r_state;
        w_credit_ok  = (SUM_W'(r_count) + SUM_W'(r_out)) < SUM_W'(DEPTH);
        w_req_valid  = rst && (r_state == S_RUN) && !bus.halt && !bus.redirect_valid
                       && w_credit_ok;
        w_req_fire   = w_req_valid && bus.imem_req_ready;
        w_rsp        = bus.imem_rsp_valid && (r_out != '0);
        w_rsp_drop   = w_rsp && (r_drop != '0);
        w_push       = w_rsp && (r_drop == '0) && !bus.redirect_valid;
        w_head_valid = rst && (r_count != '0);
        w_pop        = w_head_valid && bus.inst_ready && !bus.redirect_valid;
        w_out_next   = r_out + CNT_W'(w_req_fire) - CNT_W'(w_rsp);
        w_drop_next  = r_drop - CNT_W'(w_rsp_drop);

        case (r_state)
            S_IDLE:  w_state_next = S_RUN;
            S_RUN: begin
                if (bus.redirect_valid && (w_out_next != '0)) begin
                    w_state_next = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (!bus.redirect_valid && (w_drop_next == '0)) begin
                    w_state_next = S_RUN;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state  <= S_IDLE;
            r_pc     <= RESET_PC;
            r_rsp_pc <= RESET_PC;
            r_out    <= '0;
            r_drop   <= '0;
            r_count  <= '0;
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
        end else begin
            r_state <= w_state_next;
            r_out   <= w_out_next;
            if (bus.redirect_valid) begin
                // Everything still in flight belongs to the old path
                r_pc     <= w_redir_pc;
                r_rsp_pc <= w_redir_pc;
                r_drop   <= w_out_next;
                r_count  <= '0;
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
            end else begin
                r_drop <= w_drop_next;
                if (w_req_fire) begin
                    r_pc <= r_pc + ADDR_W'(4);
                end
                if (w_push) begin
                    r_rsp_pc <= r_rsp_pc + ADDR_W'(4);
                    r_wr_ptr <= r_wr_ptr + PTR_W'(1);
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + PTR_W'(1);
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + CNT_W'(1);
                    2'b01:   r_count <= r_count - CNT_W'(1);
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // Queue storage needs no reset: occupancy masks stale entries
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_inst_mem[r_wr_ptr] <= bus.imem_rsp_data;
            r_pc_mem[r_wr_ptr]   <= r_rsp_pc;
        end
    end

    assign bus.imem_req_valid = w_req_valid;
    assign bus.imem_req_addr  = r_pc;
    assign bus.inst_valid     = w_head_valid;
    assign bus.inst           = w_head_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
    assign bus.inst_pc        = w_head_valid ? r_pc_mem[r_rd_ptr] : '0;

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_perf_stall <= '0;
        end else if ((r_state == S_RUN) && !bus.halt && (r_count == '0)
                     && (r_perf_stall != 32'hFFFF_FFFF)) begin
            r_perf_stall <= r_perf_stall + 32'd1;
        end
    end

    assign perf_stall_cnt = r_perf_stall;
`endif

endmodule
